// File: rtl/ahb5_pkg.sv
// Shared AHB5 types and constants for the memory subordinate and its helpers.
package ahb5_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_t;

  typedef enum logic [2:0] {
    HSIZE_BYTE = 3'b000,
    HSIZE_HALF = 3'b001,
    HSIZE_WORD = 3'b010
  } hsize_t;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [2:0] {
    SLV_IDLE,
    SLV_WAIT,
    SLV_DONE,
    SLV_ERR1,
    SLV_ERR2
  } slv_state_e;

  // Sizes above a word and accesses not aligned to their own size are rejected.
  function automatic logic size_align_bad(input logic [2:0] size, input logic [1:0] lo);
    logic bad;
    bad = 1'b1;
    if (size == 3'b000) bad = 1'b0;
    else if (size == 3'b001) bad = lo[0];
    else if (size == 3'b010) bad = (lo != 2'b00);
    return bad;
  endfunction

endpackage

// File: rtl/ahb5_slave_byte_lane.sv
// Little-endian byte-enable decode and old/new word merge for sub-word AHB accesses.
module ahb5_slave_byte_lane
  import ahb5_pkg::*;
(
  input  hsize_t      size,
  input  logic [1:0]  lo,
  input  logic [31:0] old_word,
  input  logic [31:0] new_word,
  output logic [3:0]  be,
  output logic [31:0] merged
);

  always_comb begin
    be = 4'b0000;
    case (size)
      HSIZE_BYTE: be = 4'b0001 << lo;
      HSIZE_HALF: be = lo[1] ? 4'b1100 : 4'b0011;
      HSIZE_WORD: be = 4'b1111;
      default:    be = 4'b0000;
    endcase
  end

  always_comb begin
    merged = old_word;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) merged[8*i +: 8] = new_word[8*i +: 8];
    end
  end

endmodule

// File: rtl/ahb5_slave_mem.sv
// AHB5 memory subordinate: registered responses, programmable wait states,
// two-cycle ERROR on illegal accesses, and write-to-read bypass for back-to-back beats.
module ahb5_slave_mem
  import ahb5_pkg::*;
#(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    MEM_DEPTH   = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
  parameter int                    WAIT_STATES = 0
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  input  logic                  HSEL,
  input  logic [ADDR_WIDTH-1:0] HADDR,
  input  logic [1:0]            HTRANS,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [2:0]            HBURST,
  input  logic [DATA_WIDTH-1:0] HWDATA,
  input  logic                  HREADY,
  output logic [DATA_WIDTH-1:0] HRDATA,
  output logic                  HREADYOUT,
  output logic                  HRESP
);

  localparam int IDX_W = $clog2(MEM_DEPTH);

  slv_state_e             state_q, state_d;
  logic [3:0]             cnt_q, cnt_d;
  logic                   write_q, write_d;
  logic                   hreadyout_q, hreadyout_d;
  logic                   hresp_q, hresp_d;
  logic [DATA_WIDTH-1:0]  hrdata_q, hrdata_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [1:0]             lo_q, lo_d;
  hsize_t                 size_q, size_d;

  logic [DATA_WIDTH-1:0]  mem [MEM_DEPTH];
  logic [ADDR_WIDTH:0]    diff;
  logic                   in_range, illegal, accept, wr_en;
  logic [3:0]             be;
  logic [DATA_WIDTH-1:0]  rd_word, merged;
  htrans_t                trans;
  logic                   unused_ok;

  assign unused_ok = ^{HBURST, diff[1:0]};
  assign trans     = htrans_t'(HTRANS);

  // An extra top bit on the subtraction flags addresses below BASE_ADDR.
  assign diff     = {1'b0, HADDR} - {1'b0, BASE_ADDR};
  assign in_range = !diff[ADDR_WIDTH] && (diff[ADDR_WIDTH-1:0] < ADDR_WIDTH'(4 * MEM_DEPTH));
  assign illegal  = !in_range || size_align_bad(HSIZE, HADDR[1:0]);

  // Mid-WAIT and ERR1 hold the bus, so a new address phase can only land in these states.
  assign accept = HSEL && (trans == HTRANS_NONSEQ || trans == HTRANS_SEQ) && HREADY &&
                  (state_q == SLV_IDLE || state_q == SLV_DONE || state_q == SLV_ERR2);
  assign wr_en  = (state_q == SLV_DONE) && write_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    write_d = write_q;
    idx_d   = idx_q;
    lo_d    = lo_q;
    size_d  = size_q;
    case (state_q)
      SLV_WAIT: begin
        if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) state_d = SLV_DONE;
      end
      SLV_ERR1: state_d = SLV_ERR2;
      default:  state_d = SLV_IDLE;
    endcase
    if (accept) begin
      write_d = HWRITE;
      idx_d   = diff[IDX_W+1:2];
      lo_d    = HADDR[1:0];
      size_d  = hsize_t'(HSIZE);
      if (illegal) begin
        state_d = SLV_ERR1;
        cnt_d   = 4'd0;
      end else if (WAIT_STATES == 0) begin
        state_d = SLV_DONE;
        cnt_d   = 4'd0;
      end else begin
        state_d = SLV_WAIT;
        cnt_d   = 4'(WAIT_STATES);
      end
    end
  end

  ahb5_slave_byte_lane u_lane (
    .size     (size_q),
    .lo       (lo_q),
    .old_word (rd_word),
    .new_word (HWDATA),
    .be       (be),
    .merged   (merged)
  );

  // Read data is registered on the edge entering DONE; a write retiring on that
  // same edge to the same word is forwarded through the lane merge.
  assign rd_word = mem[idx_d];

  always_comb begin
    hreadyout_d = !(state_d == SLV_WAIT || state_d == SLV_ERR1);
    hresp_d     = (state_d == SLV_ERR1 || state_d == SLV_ERR2) ? HRESP_ERROR : HRESP_OKAY;
    hrdata_d    = '0;
    if (state_d == SLV_DONE && !write_d) begin
      hrdata_d = (wr_en && idx_q == idx_d) ? merged : rd_word;
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q     <= SLV_IDLE;
      cnt_q       <= 4'd0;
      write_q     <= 1'b0;
      hreadyout_q <= 1'b1;
      hresp_q     <= HRESP_OKAY;
      hrdata_q    <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      write_q     <= write_d;
      hreadyout_q <= hreadyout_d;
      hresp_q     <= hresp_d;
      hrdata_q    <= hrdata_d;
    end
  end

  always_ff @(posedge HCLK) begin
    idx_q  <= idx_d;
    lo_q   <= lo_d;
    size_q <= size_d;
  end

  always_ff @(posedge HCLK) begin
    if (wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx_q][8*i +: 8] <= HWDATA[8*i +: 8];
      end
    end
  end

  assign HRDATA    = hrdata_q;
  assign HREADYOUT = hreadyout_q;
  assign HRESP     = hresp_q;

endmodule

// File: tb/tb_ahb5_slave_mem.sv
// Scoreboard bench for ahb5_slave_mem: one zero-wait and one three-wait instance on a shared bus.
module tb_ahb5_slave_mem;

  logic        clk = 1'b0;
  logic        rst;
  logic        hsel0, hsel3, bus_w3;
  logic [31:0] haddr, hwdata;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize, hburst;
  logic [31:0] hrdata0, hrdata3;
  logic        hreadyout0, hreadyout3, hresp0, hresp3;
  logic        hready_bus;

  always #5 clk = ~clk;
  assign hready_bus = bus_w3 ? hreadyout3 : hreadyout0;

  ahb5_slave_mem #(.WAIT_STATES(0)) u_dut0 (
    .HCLK(clk), .HRESET(rst), .HSEL(hsel0), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HWDATA(hwdata),
    .HREADY(hready_bus), .HRDATA(hrdata0), .HREADYOUT(hreadyout0), .HRESP(hresp0)
  );

  ahb5_slave_mem #(.WAIT_STATES(3)) u_dut3 (
    .HCLK(clk), .HRESET(rst), .HSEL(hsel3), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HWDATA(hwdata),
    .HREADY(hready_bus), .HRDATA(hrdata3), .HREADYOUT(hreadyout3), .HRESP(hresp3)
  );

  typedef struct {
    bit          d;
    logic [31:0] data;
    logic        err;
    int          waits;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model [int];
  int          n_tests = 0;
  int          n_fail  = 0;
  bit          dp [2];
  int          wc [2];

  localparam logic [1:0] T_IDLE = 2'b00, T_BUSY = 2'b01, T_NS = 2'b10, T_SEQ = 2'b11;
  localparam logic [2:0] SZ_B = 3'b000, SZ_H = 3'b001, SZ_W = 3'b010;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic is_illegal(input logic [2:0] sz, input logic [31:0] a);
    return (sz > 3'd2) || (sz == 3'd1 && a[0]) || (sz == 3'd2 && a[1:0] != 2'b00) ||
           (a >= 32'h0000_1000);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                        input logic [2:0] sz, input logic [1:0] lo);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) begin
      if (sz == 3'd2 || (sz == 3'd1 && (b / 2) == int'(lo[1])) || (sz == 3'd0 && b == int'(lo)))
        r[8*b +: 8] = n[8*b +: 8];
    end
    return r;
  endfunction

  // Monitor: tracks each instance's data phase and retires scoreboard entries on completion.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      logic        rdy, rsp, sel;
      logic [31:0] rd;
      exp_t        e;
      rdy = d[0] ? hreadyout3 : hreadyout0;
      rsp = d[0] ? hresp3 : hresp0;
      rd  = d[0] ? hrdata3 : hrdata0;
      sel = d[0] ? hsel3 : hsel0;
      if (rst) begin
        dp[d] = 1'b0;
        wc[d] = 0;
      end else begin
        if (dp[d]) begin
          if (!rdy) begin
            wc[d]++;
            if (sb.size() > 0) begin
              check_eq("wait_rdata", rd, 32'h0);
              check_eq("wait_resp", {31'b0, rsp}, {31'b0, sb[0].err});
            end
          end else begin
            if (sb.size() == 0) begin
              check_eq("sb_nonempty", 32'(sb.size()), 32'd1);
            end else begin
              e = sb.pop_front();
              check_eq("done_dut", 32'(d), {31'b0, e.d});
              check_eq("done_resp", {31'b0, rsp}, {31'b0, e.err});
              check_eq("done_waits", 32'(wc[d]), 32'(e.waits));
              check_eq("done_rdata", rd, e.data);
            end
            dp[d] = 1'b0;
          end
        end else begin
          check_eq("idle_rdy", {31'b0, rdy}, 32'd1);
          check_eq("idle_resp", {31'b0, rsp}, 32'd0);
          check_eq("idle_rdata", rd, 32'h0);
        end
        if (sel && htrans[1] && hready_bus) begin
          dp[d] = 1'b1;
          wc[d] = 0;
        end
      end
    end
  end

  task automatic beat(input bit d, input logic [1:0] tr, input logic wr, input logic [2:0] sz,
                      input logic [31:0] a, input logic [31:0] wd, input bit push);
    bit   ok;
    exp_t e;
    int   k;
    bus_w3 = d;
    hsel0  = !d;
    hsel3  = d;
    htrans = tr;
    hwrite = wr;
    hsize  = sz;
    haddr  = a;
    ok     = 1'b0;
    for (int n = 0; n < 64 && !ok; n++) begin
      @(negedge clk);
      ok = hready_bus;
      @(posedge clk);
      #1;
    end
    if (!ok) check_eq("accept_timeout", {31'b0, ok}, 32'd1);
    if (ok && tr[1]) begin
      hwdata = wd;
      if (push) begin
        e.d     = d;
        e.err   = is_illegal(sz, a);
        e.waits = e.err ? 1 : (d ? 3 : 0);
        e.data  = 32'h0;
        k       = (d ? 65536 : 0) + int'(a[11:2]);
        if (!e.err) begin
          if (wr) model[k] = merge(model.exists(k) ? model[k] : 32'h0, wd, sz, a[1:0]);
          else    e.data   = model.exists(k) ? model[k] : 32'h0;
        end
        sb.push_back(e);
      end
    end
  endtask

  task automatic drain();
    htrans = T_IDLE;
    for (int n = 0; n < 64 && sb.size() != 0; n++) @(negedge clk);
    check_eq("drain", 32'(sb.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; hsel0 = 1'b0; hsel3 = 1'b0; bus_w3 = 1'b0; haddr = '0; htrans = T_IDLE;
    hwrite = 1'b0; hsize = SZ_W; hburst = 3'b000; hwdata = '0;
    repeat (2) @(negedge clk);
    check_eq("rst_rdy0", {31'b0, hreadyout0}, 32'd1);
    check_eq("rst_resp0", {31'b0, hresp0}, 32'd0);
    check_eq("rst_rdata0", hrdata0, 32'h0);
    check_eq("rst_rdy3", {31'b0, hreadyout3}, 32'd1);
    check_eq("rst_resp3", {31'b0, hresp3}, 32'd0);
    check_eq("rst_rdata3", hrdata3, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Back-to-back write then read of the same word: needs bypass.
    beat(0, T_NS, 1'b1, SZ_W, 32'h10, 32'hDEAD_BEEF, 1'b1);
    beat(0, T_NS, 1'b0, SZ_W, 32'h10, 32'h0, 1'b1);
    drain();

    beat(0, T_NS, 1'b1, SZ_W, 32'h30, 32'h1122_3344, 1'b1);
    beat(0, T_NS, 1'b1, SZ_B, 32'h31, 32'h0000_AA00, 1'b1);
    beat(0, T_NS, 1'b0, SZ_W, 32'h30, 32'h0, 1'b1);
    beat(0, T_NS, 1'b1, SZ_H, 32'h32, 32'hBEEF_0000, 1'b1);
    beat(0, T_NS, 1'b0, SZ_W, 32'h30, 32'h0, 1'b1);
    drain();

    // Illegal accesses must not touch memory.
    beat(0, T_NS, 1'b1, SZ_W, 32'h08, 32'h0000_0055, 1'b1);
    beat(0, T_NS, 1'b1, SZ_W, 32'h1002, 32'hFFFF_FFFF, 1'b1);
    beat(0, T_NS, 1'b1, SZ_W, 32'h4000, 32'hFFFF_FFFF, 1'b1);
    beat(0, T_NS, 1'b1, 3'b011, 32'h08, 32'hFFFF_FFFF, 1'b1);
    beat(0, T_NS, 1'b1, SZ_H, 32'h09, 32'hFFFF_FFFF, 1'b1);
    beat(0, T_NS, 1'b0, SZ_W, 32'h08, 32'h0, 1'b1);
    drain();

    // INCR4 with BUSY cycles between beats.
    hburst = 3'b011;
    beat(0, T_NS,   1'b1, SZ_W, 32'h0, 32'hC000_0000, 1'b1);
    beat(0, T_BUSY, 1'b1, SZ_W, 32'h4, 32'h0, 1'b0);
    beat(0, T_SEQ,  1'b1, SZ_W, 32'h4, 32'hC000_0004, 1'b1);
    beat(0, T_BUSY, 1'b1, SZ_W, 32'h8, 32'h0, 1'b0);
    beat(0, T_SEQ,  1'b1, SZ_W, 32'h8, 32'hC000_0008, 1'b1);
    beat(0, T_SEQ,  1'b1, SZ_W, 32'hC, 32'hC000_000C, 1'b1);
    drain();
    hburst = 3'b000;
    for (int i = 0; i < 4; i++) beat(0, T_NS, 1'b0, SZ_W, 32'(4 * i), 32'h0, 1'b1);
    drain();

    // Three wait states per OKAY beat; errors stay two cycles.
    beat(1, T_NS, 1'b1, SZ_W, 32'h20, 32'hA5A5_0F0F, 1'b1);
    beat(1, T_NS, 1'b0, SZ_W, 32'h20, 32'h0, 1'b1);
    beat(1, T_NS, 1'b1, 3'b100, 32'h24, 32'h1234_5678, 1'b1);
    beat(1, T_NS, 1'b0, SZ_B, 32'h23, 32'h0, 1'b1);
    drain();

    // Reset during the second wait state of a write aborts it.
    beat(1, T_NS, 1'b1, SZ_W, 32'h40, 32'h1234_5678, 1'b1);
    drain();
    beat(1, T_NS, 1'b1, SZ_W, 32'h40, 32'hCAFE_F00D, 1'b0);
    htrans = T_IDLE;
    @(posedge clk);
    @(negedge clk);
    check_eq("pre_abort_rdy", {31'b0, hreadyout3}, 32'd0);
    rst = 1'b1;
    #1;
    check_eq("abort_rdy", {31'b0, hreadyout3}, 32'd1);
    check_eq("abort_resp", {31'b0, hresp3}, 32'd0);
    check_eq("abort_rdata", hrdata3, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    beat(1, T_NS, 1'b0, SZ_W, 32'h40, 32'h0, 1'b1);
    drain();

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
